// File: rtl/led_step_ctrl.sv
// Key debounce and run/pause step-rate control for the LED rotator; a press strobe follows a key by DEBOUNCE_MAX+4 edges.
// Define LED_STEP_CTRL_SINGLESTEP_EN to make the direction key single-step the rotator while paused.
module led_step_ctrl #(
  parameter logic [19:0] DEBOUNCE_MAX = 20'd999_999,
  parameter logic [24:0] PER_S0       = 25'd24_999_999,
  parameter logic [24:0] PER_S1       = 25'd12_499_999,
  parameter logic [24:0] PER_S2       = 25'd6_249_999,
  parameter logic [24:0] PER_S3       = 25'd3_124_999
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [2:0] key_n,
  output logic [2:0] key_press,
  output logic       step,
  output logic       dir,
  output logic       running,
  output logic [1:0] speed
);

  typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} state_t;

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       stable_q, stable_d;
  logic [2:0]       stable_dly_q, stable_dly_d;
  logic [2:0]       key_press_q, key_press_d;
  logic [2:0][19:0] db_cnt_q, db_cnt_d;
  logic [24:0]      per_cnt_q, per_cnt_d;
  logic [1:0]       speed_q, speed_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  state_t           state_q, state_d;
  logic [24:0]      per_sel;
  logic             per_hit;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 3'b111;
      sync2_q      <= 3'b111;
      stable_q     <= 3'b111;
      stable_dly_q <= 3'b111;
      key_press_q  <= 3'b000;
      db_cnt_q     <= '0;
      per_cnt_q    <= '0;
      speed_q      <= 2'd0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      state_q      <= ST_RUN;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      key_press_q  <= key_press_d;
      db_cnt_q     <= db_cnt_d;
      per_cnt_q    <= per_cnt_d;
      speed_q      <= speed_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      state_q      <= state_d;
    end
  end

  // Any sample that agrees with the stable level restarts the debounce count.
  always_comb begin
    sync1_d      = key_n;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    db_cnt_d     = db_cnt_q;
    stable_dly_d = stable_q;
    key_press_d  = stable_dly_q & ~stable_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DEBOUNCE_MAX) begin
          stable_d[i] = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 20'd1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    case (speed_q)
      2'd0:    per_sel = PER_S0;
      2'd1:    per_sel = PER_S1;
      2'd2:    per_sel = PER_S2;
      default: per_sel = PER_S3;
    endcase
  end

  assign per_hit = (per_cnt_q == per_sel);

  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q + {1'b0, key_press_q[1]};
    dir_d     = dir_q;
    per_cnt_d = per_cnt_q;
    step_d    = 1'b0;

    if (key_press_q[0]) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end

    // A speed change restarts the period and suppresses that cycle's step.
    if (key_press_q[1]) begin
      per_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      per_cnt_d = per_hit ? '0 : per_cnt_q + 25'd1;
      step_d    = per_hit;
    end

`ifdef LED_STEP_CTRL_SINGLESTEP_EN
    if (key_press_q[2]) begin
      if (state_q == ST_RUN) begin
        dir_d = ~dir_q;
      end else begin
        step_d = 1'b1;
      end
    end
`else
    if (key_press_q[2]) begin
      dir_d = ~dir_q;
    end
`endif
  end

  assign key_press = key_press_q;
  assign step      = step_q;
  assign dir       = dir_q;
  assign running   = (state_q == ST_RUN);
  assign speed     = speed_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Randomized and directed bench for led_step_ctrl against a behavioural model, with small debounce/period overrides.
module tb_led_step_ctrl;

  localparam int DMAX = 3;

  logic       clk_50 = 1'b0;
  logic       reset  = 1'b0;
  logic [2:0] key_n  = 3'b111;
  logic [2:0] key_press;
  logic       step;
  logic       dir;
  logic       running;
  logic [1:0] speed;

  int total = 0;
  int bad   = 0;
  int press_cnt [3] = '{0, 0, 0};
  int step_cnt  = 0;

  always #10 clk_50 = ~clk_50;

  led_step_ctrl #(
    .DEBOUNCE_MAX(20'd3),
    .PER_S0      (25'd15),
    .PER_S1      (25'd7),
    .PER_S2      (25'd3),
    .PER_S3      (25'd1)
  ) dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .key_n    (key_n),
    .key_press(key_press),
    .step     (step),
    .dir      (dir),
    .running  (running),
    .speed    (speed)
  );

  // Reference: raw key samples go through a 2-deep delay; a key's stable level
  // flips once DMAX+1 consecutive delayed samples disagree with it. Press strobes
  // show one edge after the stable level falls. Step cadence is a position in
  // the current period.
  typedef struct packed {
    logic [2:0]      s1;
    logic [2:0]      s2;
    logic [2:0]      stab;
    logic [2:0]      fell;
    logic [2:0]      press;
    logic [2:0][7:0] streak;
    logic [7:0]      pos;
    logic            run;
    logic [1:0]      speed;
    logic            dir;
    logic            step;
  } model_t;

  model_t m;

  function automatic logic [7:0] period_len(input logic [1:0] s);
    case (s)
      2'd0:    return 8'd16;
      2'd1:    return 8'd8;
      2'd2:    return 8'd4;
      default: return 8'd2;
    endcase
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r        = '0;
    r.s1     = 3'b111;
    r.s2     = 3'b111;
    r.stab   = 3'b111;
    r.run    = 1'b1;
    return r;
  endfunction

  function automatic model_t model_next(input model_t c, input logic [2:0] raw);
    model_t n;
    logic   last_of_period;
    n      = c;
    n.s1   = raw;
    n.s2   = c.s1;
    n.fell = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (c.s2[i] == c.stab[i]) begin
        n.streak[i] = 8'd0;
      end else if (int'(c.streak[i]) + 1 == DMAX + 1) begin
        n.stab[i]   = c.s2[i];
        n.streak[i] = 8'd0;
        n.fell[i]   = ~c.s2[i];
      end else begin
        n.streak[i] = c.streak[i] + 8'd1;
      end
    end
    n.press = c.fell;

    last_of_period = (c.pos + 8'd1 == period_len(c.speed));
    n.step  = c.run && last_of_period && !c.press[1];
    if (c.press[1])  n.pos = 8'd0;
    else if (c.run)  n.pos = last_of_period ? 8'd0 : c.pos + 8'd1;
    n.speed = c.speed + {1'b0, c.press[1]};
    n.run   = c.run ^ c.press[0];
`ifdef LED_STEP_CTRL_SINGLESTEP_EN
    if (c.press[2]) begin
      if (c.run) n.dir  = ~c.dir;
      else       n.step = 1'b1;
    end
`else
    if (c.press[2]) n.dir = ~c.dir;
`endif
    return n;
  endfunction

  always @(posedge clk_50 or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_next(m, key_n);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_step(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk_50);
      n++;
    end while (!step && n < limit);
    check("step_seen", int'(step), 1);
  endtask

  task automatic press(input int k, input int hold);
    @(negedge clk_50);
    key_n[k] = 1'b0;
    repeat (hold) @(negedge clk_50);
    key_n[k] = 1'b1;
    repeat (12) @(negedge clk_50);
  endtask

  task automatic period_is(input string name, input int exp);
    int n;
    wait_step(40, n);
    wait_step(40, n);
    check(name, n, exp);
  endtask

  initial begin : main
    int n;
    int snap;
    int snap_p;

    fork
      forever begin
        @(negedge clk_50);
        check("key_press", int'(key_press), int'(m.press));
        check("step",      int'(step),      int'(m.step));
        check("dir",       int'(dir),       int'(m.dir));
        check("running",   int'(running),   int'(m.run));
        check("speed",     int'(speed),     int'(m.speed));
        for (int i = 0; i < 3; i++) press_cnt[i] += int'(key_press[i]);
        step_cnt += int'(step);
      end
    join_none

    // Reset values, first step and base period.
    repeat (3) @(negedge clk_50);
    check("rst_running", int'(running), 1);
    check("rst_speed",   int'(speed),   0);
    check("rst_dir",     int'(dir),     0);
    check("rst_step",    int'(step),    0);
    #2 reset = 1'b1;
    wait_step(40, n);
    check("first_step", n, 16);
    wait_step(40, n);
    check("period_s0", n, 16);

    // Bounce shorter than the debounce window is ignored.
    @(negedge clk_50);
    key_n[1] = 1'b0; repeat (2) @(negedge clk_50);
    key_n[1] = 1'b1; repeat (1) @(negedge clk_50);
    key_n[1] = 1'b0; repeat (2) @(negedge clk_50);
    key_n[1] = 1'b1; repeat (12) @(negedge clk_50);
    check("bounce_press", press_cnt[1], 0);
    check("bounce_speed", int'(speed), 0);

    // Held press: strobe latency, then new speed and period.
    @(negedge clk_50);
    key_n[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk_50);
      n++;
    end while (!key_press[1] && n < 20);
    check("press_latency", n, 7);
    repeat (3) @(negedge clk_50);
    key_n[1] = 1'b1;
    repeat (12) @(negedge clk_50);
    check("press_count", press_cnt[1], 1);
    check("speed_1", int'(speed), 1);
    period_is("period_s1", 8);

    press(1, 8); check("speed_2", int'(speed), 2); period_is("period_s2", 4);
    press(1, 8); check("speed_3", int'(speed), 3); period_is("period_s3", 2);
    press(1, 8); check("speed_0", int'(speed), 0); period_is("period_s0b", 16);

    // Pause holds off steps; resume restores cadence.
    press(0, 8);
    check("paused", int'(running), 0);
    snap = step_cnt;
    repeat (100) @(negedge clk_50);
    check("pause_steps", step_cnt - snap, 0);
    press(0, 8);
    check("resumed", int'(running), 1);
    period_is("period_resume", 16);

    // Direction key in RUN, then in PAUSE.
    press(2, 8);
    check("dir_run", int'(dir), 1);
    period_is("period_dir", 16);
    press(0, 8);
    snap = step_cnt;
    press(2, 8);
`ifdef LED_STEP_CTRL_SINGLESTEP_EN
    check("single_step", step_cnt - snap, 1);
    check("dir_pause", int'(dir), 1);
`else
    check("pause_no_step", step_cnt - snap, 0);
    check("dir_pause", int'(dir), 0);
`endif
    press(0, 8);

    // Reset in the middle of a debounce and a period.
    @(negedge clk_50);
    key_n[1] = 1'b0;
    repeat (3) @(negedge clk_50);
    #2 reset = 1'b0;
    #1;
    check("arst_running", int'(running), 1);
    check("arst_speed",   int'(speed),   0);
    check("arst_dir",     int'(dir),     0);
    check("arst_step",    int'(step),    0);
    check("arst_press",   int'(key_press), 0);
    key_n[1] = 1'b1;
    repeat (3) @(negedge clk_50);
    snap_p = press_cnt[1];
    #2 reset = 1'b1;
    wait_step(40, n);
    check("arst_first_step", n, 16);
    check("arst_no_press", press_cnt[1] - snap_p, 0);

    // Random key activity, including simultaneous keys and occasional resets.
    for (int it = 0; it < 300; it++) begin
      @(negedge clk_50);
      if ($urandom_range(0, 49) == 0) begin
        #2 reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk_50);
        #2 reset = 1'b1;
      end
      key_n = ~3'($urandom_range(1, 7));
      repeat ($urandom_range(1, 9)) @(negedge clk_50);
      key_n = 3'b111;
      repeat ($urandom_range(0, 12)) @(negedge clk_50);
    end
    repeat (20) @(negedge clk_50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
